pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the mips32 fetch stage. It holds the current fetch address and selects the next one from exception, return, jump, branch or sequential sources under a fixed priority. It has a stall input and a circular return-address stack (RAS) for call/return prediction. It captures the faulting PC for the exception handler.

## Interface
- WIDTH, 32: address width in bits.
- INCR, 4: sequential increment (bytes per instruction).
- RESET_VECTOR, 32'h0000_0000: PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0080: handler address loaded on exception.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC; ignored when exception=1.
- exception  in  1  redirect to EXC_VECTOR, capture EPC.
- branch_taken  in  1  load branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  load jump_target.
- jump_target  in  WIDTH  jump destination.
- call  in  1  push pc+INCR onto RAS (jal/jalr).
- ret  in  1  load popped RAS top (jr $ra).
- pc_out  out  WIDTH  current fetch address (registered).
- pc_plus  out  WIDTH  pc_out+INCR, combinational.
- epc  out  WIDTH  PC captured at last exception.
- ras_empty  out  1  RAS count = 0.
- ras_full  out  1  RAS count = RAS_DEPTH.
- ret_miss  out  1  one-cycle pulse: ret with empty RAS.
- align_err  out  1  one-cycle pulse: loaded target has nonzero bits below log2(INCR).

## Operation
- Next-PC priority: exception > stall (hold) > ret > jump > branch_taken > sequential (pc_out+INCR). The value is written on the clock edge.
- Exception: next PC = EXC_VECTOR. epc ← pc_out. The RAS is unchanged. call/ret in the same cycle are ignored.
- Stall without exception: PC, RAS, epc and pulses are all held. call/ret are ignored (no push/pop).
- ret with count>0: next PC = top entry, pop.
- ret with count=0: next PC = pc_out+INCR, ret_miss=1, no pop.
- call: push pc_out+INCR. It is independent of the jump/branch target selection.
- call when full: overwrite the oldest entry (circular), count stays RAS_DEPTH.
- call and ret in the same cycle: target = current top, then the top entry is replaced by pc_out+INCR. Count is unchanged. If empty: ret_miss=1 and a push occurs.
- align_err: asserted when the selected ret/jump/branch target is misaligned. The target is still loaded unmodified.
- Arithmetic: all additions are modulo 2^WIDTH. pc_out=all-ones−INCR+1 wraps to 0.

## Timing
- Reset (async, any time, including mid-stall or mid-redirect): pc_out=RESET_VECTOR, epc=0, RAS count=0, ras_empty=1, ras_full=0, ret_miss=0, align_err=0.
- After reset release, the first edge loads RESET_VECTOR+INCR unless a redirect is present.
- Redirect latency is 1 cycle: a request sampled at edge N appears on pc_out after edge N.
- ret_miss and align_err are registered and valid in the cycle after the triggering request.
- RAS push/pop take effect at the same edge as the PC update. ras_empty and ras_full are registered.

## Structure
- Shared package pc_pkg holds the next-PC source encoding (SRC_SEQ, SRC_BR, SRC_JMP, SRC_RET, SRC_EXC, SRC_HOLD) and the default vectors.
- Sub-module ras_stack(WIDTH, RAS_DEPTH) contains the circular array, top pointer, count, push/pop/replace, and empty/full.
- pc_unit keeps the priority mux, PC register, epc register and pulse flags.

## Test plan
- Reset then 3 free-running cycles -> pc_out 0x0, 0x4, 0x8, 0xC; assert reset mid-run -> pc_out=0x0 immediately.
- pc_out=0x10, jump=1 jump_target=0x40 with branch_taken=1 branch_target=0x80 -> pc_out=0x40; jump_target=0x42 -> align_err pulse, pc_out=0x42.
- stall=1 for 3 cycles at 0x20 with call=1 -> pc_out stays 0x20, RAS count unchanged; stall+exception -> pc_out=0x80, epc=0x20.
- 5 calls at 0x100, 0x200, 0x300, 0x400, 0x500 (RAS_DEPTH=4) -> ras_full; 4 rets -> 0x504, 0x404, 0x304, 0x204; 5th ret -> ret_miss, pc_out=sequential.
- call+ret same cycle at pc 0x60, top=0x204 -> pc_out=0x204, top becomes 0x64, count unchanged.
- pc_out=0xFFFF_FFFC sequential -> pc_out=0x0000_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Holds the next-PC source encoding and the default reset and exception vectors.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_RET,
    SRC_EXC,
    SRC_HOLD
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the fetch control and pc_unit.
//   master: drives stall, exception, branch/jump requests, call and ret;
//           observes pc_out, pc_plus, epc, ras_empty, ras_full, ret_miss and align_err.
//   slave : the pc_unit side.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             exception;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;
  logic             ret_miss;
  logic             align_err;

  modport master (
    output stall, exception, branch_taken, branch_target, jump, jump_target, call, ret,
    input  pc_out, pc_plus, epc, ras_empty, ras_full, ret_miss, align_err
  );

  modport slave (
    input  stall, exception, branch_taken, branch_target, jump, jump_target, call, ret,
    output pc_out, pc_plus, epc, ras_empty, ras_full, ret_miss, align_err
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din as the new top entry
//   pop      : drop the top entry
//   push+pop : replace the top entry with din (count unchanged)
//   din      : value to push
//   top      : current top entry
//   empty    : registered, count == 0
//   full     : registered, count == RAS_DEPTH
// A push when full overwrites the oldest entry; the count saturates.
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;  // index of the top entry
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic             empty_q, full_q;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && pop && !empty_q) begin
      wr_en = 1'b1;
    end else if (push) begin
      // Advancing the pointer past the newest entry lands on the oldest when full.
      ptr_d  = ptr_q + 1'b1;
      wr_idx = ptr_d;
      wr_en  = 1'b1;
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty_q) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == DEPTH_C);
      if (wr_en) mem_q[wr_idx] <= din;
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_unit_if slave; redirect requests in, fetch address and status out
// Next-PC priority: exception > stall > ret > jump > branch > sequential.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INCR         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  localparam logic [WIDTH-1:0] INCR_W     = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << $clog2(INCR)) - 64'd1);

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_plus, ras_top;
  logic             ret_miss_q, ret_miss_d, align_err_q, align_err_d;
  logic             active, ras_push, ras_pop, ras_empty, ras_full;
  pc_src_e          src;

  assign pc_plus = pc_q + INCR_W;

  always_comb begin
    src = SRC_SEQ;
    if (bus.exception)         src = SRC_EXC;
    else if (bus.stall)        src = SRC_HOLD;
    else if (bus.ret)          src = ras_empty ? SRC_SEQ : SRC_RET;  // empty: fall through
    else if (bus.jump)         src = SRC_JMP;
    else if (bus.branch_taken) src = SRC_BR;

    unique case (src)
      SRC_EXC:  pc_d = EXC_VECTOR;
      SRC_HOLD: pc_d = pc_q;
      SRC_RET:  pc_d = ras_top;
      SRC_JMP:  pc_d = bus.jump_target;
      SRC_BR:   pc_d = bus.branch_target;
      default:  pc_d = pc_plus;
    endcase

    // Call/ret only act when the PC actually advances normally.
    active   = !bus.exception && !bus.stall;
    ras_push = active && bus.call;
    ras_pop  = active && bus.ret && !ras_empty;

    epc_d       = bus.exception ? pc_q : epc_q;
    ret_miss_d  = ret_miss_q;
    align_err_d = align_err_q;
    if (bus.exception) begin
      ret_miss_d  = 1'b0;
      align_err_d = 1'b0;
    end else if (!bus.stall) begin
      ret_miss_d  = bus.ret && ras_empty;
      align_err_d = (src inside {SRC_RET, SRC_JMP, SRC_BR}) && (|(pc_d & ALIGN_MASK));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      ret_miss_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      ret_miss_q  <= ret_miss_d;
      align_err_q <= align_err_d;
    end
  end

  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (pc_plus),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

  assign bus.pc_out    = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.epc       = epc_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ret_miss  = ret_miss_q;
  assign bus.align_err = align_err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH       (32),
    .INCR        (4),
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h0000_0080),
    .RAS_DEPTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st, ex, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        cl, rt;
    logic [31:0] pc, epc;
    logic        emp, full, miss, alg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic ex, logic br, logic [31:0] bt, logic jp,
                              logic [31:0] jt, logic cl, logic rt, logic [31:0] pc,
                              logic [31:0] epc, logic emp, logic full, logic miss, logic alg);
    vec_t v;
    v.st = st; v.ex = ex; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt; v.cl = cl; v.rt = rt;
    v.pc = pc; v.epc = epc; v.emp = emp; v.full = full; v.miss = miss; v.alg = alg;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.stall = 0; bus.exception = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.call = 0; bus.ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    // Reset state while reset is held
    #12;
    chk("reset pc", bus.pc_out, 32'h0);
    chk("reset epc", bus.epc, 32'h0);
    chk("reset empty", 32'(bus.ras_empty), 32'd1);
    chk("reset full", 32'(bus.ras_full), 32'd0);
    chk("reset miss", 32'(bus.ret_miss), 32'd0);
    chk("reset align", 32'(bus.align_err), 32'd0);

    // Free running after release
    @(negedge clk); rst = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("free run %0d", i), bus.pc_out, 32'(i * 4));
    end

    // Asynchronous reset mid-run takes effect without a clock edge
    @(negedge clk); rst = 1; #1;
    chk("async reset pc", bus.pc_out, 32'h0);
    @(negedge clk); rst = 0;

    // Build some state, then reset in the middle of a stalled redirect
    bus.call = 1;
    @(posedge clk); #1;
    chk("pre push empty", 32'(bus.ras_empty), 32'd0);
    @(negedge clk); bus.call = 0; bus.exception = 1;
    @(posedge clk); #1;
    chk("pre exc epc", bus.epc, 32'h4);
    @(negedge clk); bus.exception = 0; bus.stall = 1; bus.jump = 1; bus.jump_target = 32'h40;
    @(posedge clk); #2;
    rst = 1; #1;
    chk("mid-stall reset pc", bus.pc_out, 32'h0);
    chk("mid-stall reset epc", bus.epc, 32'h0);
    chk("mid-stall reset empty", 32'(bus.ras_empty), 32'd1);
    @(posedge clk); #1;
    chk("reset held pc", bus.pc_out, 32'h0);
    @(negedge clk); clear_inputs(); rst = 0;

    //               st ex br bt            jp jt            cl rt pc             epc   e  f  m  a
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h10,       0, 0, 32'h10,       0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80,      1, 32'h40,       0, 0, 32'h40,       0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h42,       0, 0, 32'h42,       0,    1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0,            0, 0, 32'h42,       0,    1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h20,       0, 0, 32'h20,       0,    1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0,            1, 0, 32'h20,       0,    1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0,            1, 0, 32'h20,       0,    1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0,            1, 0, 32'h20,       0,    1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,           0, 0,            0, 0, 32'h80,       32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h100,      0, 0, 32'h100,      32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h200,      1, 0, 32'h200,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h300,      1, 0, 32'h300,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h400,      1, 0, 32'h400,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h500,      1, 0, 32'h500,      32'h20, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            1, 0, 32'h504,      32'h20, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h504,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h404,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h304,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h204,      32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h208,      32'h20, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 0, 32'h20c,      32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h200,      0, 0, 32'h200,      32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h60,       1, 0, 32'h60,       32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            1, 1, 32'h204,      32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h64,       32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            1, 1, 32'h68,       32'h20, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h68,       32'h20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            1, 0, 32'h6c,       32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,           0, 0,            1, 1, 32'h80,       32'h6c, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 1, 32'h6c,       32'h6c, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'h300,      1, 0, 32'h300,      32'h6c, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h500,     1, 32'h400,      0, 1, 32'h70,       32'h6c, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h1000,    0, 0,            0, 0, 32'h1000,     32'h6c, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h1001,    0, 0,            0, 0, 32'h1001,     32'h6c, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,           1, 32'hffff_fffc, 0, 0, 32'hffff_fffc, 32'h6c, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 0, 32'h0,        32'h6c, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0,            0, 0, 32'h4,        32'h6c, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.stall = vecs[i].st; bus.exception = vecs[i].ex;
      bus.branch_taken = vecs[i].br; bus.branch_target = vecs[i].bt;
      bus.jump = vecs[i].jp; bus.jump_target = vecs[i].jt;
      bus.call = vecs[i].cl; bus.ret = vecs[i].rt;
      @(posedge clk); #1;
      chk($sformatf("v%0d pc", i), bus.pc_out, vecs[i].pc);
      chk($sformatf("v%0d pc_plus", i), bus.pc_plus, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d epc", i), bus.epc, vecs[i].epc);
      chk($sformatf("v%0d empty", i), 32'(bus.ras_empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d full", i), 32'(bus.ras_full), 32'(vecs[i].full));
      chk($sformatf("v%0d ret_miss", i), 32'(bus.ret_miss), 32'(vecs[i].miss));
      chk($sformatf("v%0d align_err", i), 32'(bus.align_err), 32'(vecs[i].alg));
    end

    @(negedge clk); clear_inputs();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
